// File: rtl/score_if.sv
// Buzzer/judge handshake and score display bundle between the host panel and score_keeper.
interface score_if;
  logic       win_valid;
  logic [1:0] win_id;
  logic       win_ready;
  logic       judge_ok;
  logic       judge_bad;
  logic       score_clear;
  logic [2:0] led;
  logic [1:0] result;
  logic [7:0] score1;
  logic [7:0] score2;
  logic [7:0] score3;

  modport master (
    output win_valid, win_id, judge_ok, judge_bad, score_clear,
    input  win_ready, led, result, score1, score2, score3
  );

  modport slave (
    input  win_valid, win_id, judge_ok, judge_bad, score_clear,
    output win_ready, led, result, score1, score2, score3
  );
endinterface

// File: rtl/score_keeper.sv
// Quiz score keeper: takes a buzzer winner, waits for the host verdict or a timeout,
// updates that team's saturating score and holds the result display.
//
// state   | meaning
// IDLE    | waiting for a buzzer winner, win_ready high
// JUDGE   | latched team shown on led, timer running, awaiting verdict
// HOLD    | result shown for HOLD_CYCLES cycles
module score_keeper #(
  parameter int unsigned JUDGE_TIMEOUT = 300_000_000,
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned PTS_CORRECT   = 10,
  parameter int unsigned PTS_WRONG     = 5
) (
  input  logic    clk,
  input  logic    rst,
  score_if.slave  sk
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_JUDGE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [1:0] R_NONE    = 2'd0;
  localparam logic [1:0] R_CORRECT = 2'd1;
  localparam logic [1:0] R_WRONG   = 2'd2;
  localparam logic [1:0] R_TIMEOUT = 2'd3;

  logic [1:0]  state;
  logic [1:0]  team;
  logic [31:0] timer;
  logic [31:0] hold_cnt;
  logic        ok_q, bad_q;
  logic [1:0]  result_q;
  logic [7:0]  score1_q, score2_q, score3_q;

  logic        ok_edge, bad_edge;
  logic        accept;
  logic        verdict_ok, verdict_bad;
  logic [7:0]  cur_score;
  logic [8:0]  sum9, diff9;
  logic [7:0]  inc_val, dec_val;
  logic [7:0]  new_score;

  assign ok_edge  = sk.judge_ok  & ~ok_q;
  assign bad_edge = sk.judge_bad & ~bad_q;

  assign accept      = sk.win_valid && (state == S_IDLE) && (sk.win_id != 2'd0);
  assign verdict_ok  = (state == S_JUDGE) && ok_edge && !bad_edge;
  assign verdict_bad = (state == S_JUDGE) && bad_edge && !ok_edge;

  always_comb begin
    cur_score = 8'd0;
    case (team)
      2'd1:    cur_score = score1_q;
      2'd2:    cur_score = score2_q;
      2'd3:    cur_score = score3_q;
      default: cur_score = 8'd0;
    endcase
  end

  // 9-bit intermediates: bit 8 flags overflow on add and borrow on subtract.
  assign sum9      = {1'b0, cur_score} + 9'(PTS_CORRECT);
  assign diff9     = {1'b0, cur_score} - 9'(PTS_WRONG);
  assign inc_val   = sum9[8]  ? 8'hFF : sum9[7:0];
  assign dec_val   = diff9[8] ? 8'h00 : diff9[7:0];
  assign new_score = verdict_ok ? inc_val : dec_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      team     <= 2'd0;
      timer    <= 32'd0;
      hold_cnt <= 32'd0;
      ok_q     <= 1'b0;
      bad_q    <= 1'b0;
      result_q <= R_NONE;
      score1_q <= 8'd0;
      score2_q <= 8'd0;
      score3_q <= 8'd0;
    end else begin
      ok_q  <= sk.judge_ok;
      bad_q <= sk.judge_bad;
      if (sk.score_clear) begin
        state    <= S_IDLE;
        timer    <= 32'd0;
        hold_cnt <= 32'd0;
        result_q <= R_NONE;
        score1_q <= 8'd0;
        score2_q <= 8'd0;
        score3_q <= 8'd0;
      end else begin
        if (verdict_ok || verdict_bad) begin
          case (team)
            2'd1:    score1_q <= new_score;
            2'd2:    score2_q <= new_score;
            2'd3:    score3_q <= new_score;
            default: ;
          endcase
        end
        case (state)
          S_IDLE: begin
            if (accept) begin
              team  <= sk.win_id;
              timer <= 32'd0;
              state <= S_JUDGE;
            end
          end
          S_JUDGE: begin
            if (verdict_ok || verdict_bad) begin
              result_q <= verdict_ok ? R_CORRECT : R_WRONG;
              hold_cnt <= 32'(HOLD_CYCLES - 1);
              state    <= S_HOLD;
            end else if (timer == 32'(JUDGE_TIMEOUT - 1)) begin
              result_q <= R_TIMEOUT;
              hold_cnt <= 32'(HOLD_CYCLES - 1);
              state    <= S_HOLD;
            end else begin
              timer <= timer + 32'd1;
            end
          end
          S_HOLD: begin
            if (hold_cnt == 32'd0) begin
              result_q <= R_NONE;
              state    <= S_IDLE;
            end else begin
              hold_cnt <= hold_cnt - 32'd1;
            end
          end
          default: begin
            result_q <= R_NONE;
            state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sk.win_ready = (state == S_IDLE);
  assign sk.result    = result_q;
  assign sk.score1    = score1_q;
  assign sk.score2    = score2_q;
  assign sk.score3    = score3_q;
  assign sk.led       = (state == S_IDLE) ? 3'b000 :
                        (team == 2'd1)    ? 3'b100 :
                        (team == 2'd2)    ? 3'b010 :
                        (team == 2'd3)    ? 3'b001 : 3'b000;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with short timeout/hold parameters.
module tb_score_keeper;
  localparam int TO   = 20;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  score_if sk();

  score_keeper #(
    .JUDGE_TIMEOUT(TO), .HOLD_CYCLES(HOLD), .PTS_CORRECT(10), .PTS_WRONG(5)
  ) dut (
    .clk(clk), .rst(rst), .sk(sk)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] t);
    sk.win_valid = 1'b1; sk.win_id = t;
    tick();
    sk.win_valid = 1'b0; sk.win_id = 2'd0;
  endtask

  task automatic pulse_ok();
    sk.judge_ok = 1'b1; tick(); sk.judge_ok = 1'b0;
  endtask

  task automatic pulse_bad();
    sk.judge_bad = 1'b1; tick(); sk.judge_bad = 1'b0;
  endtask

  task automatic hold_out();
    repeat (HOLD) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (sk.win_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", sk.win_ready); end
    checks++; if (sk.led !== 3'b000) begin failures++; $display("FAIL reset_led got=%b exp=000", sk.led); end
    checks++; if (sk.result !== 2'd0) begin failures++; $display("FAIL reset_result got=%0d exp=0", sk.result); end
    checks++; if ({sk.score1, sk.score2, sk.score3} !== 24'd0) begin failures++; $display("FAIL reset_scores got=%0d/%0d/%0d exp=0/0/0", sk.score1, sk.score2, sk.score3); end
  endtask

  task automatic test_correct();
    int n;
    accept(2'd2);
    checks++; if (sk.led !== 3'b010 || sk.win_ready !== 1'b0 || sk.result !== 2'd0) begin failures++; $display("FAIL correct_judge led=%b ready=%b result=%0d exp led=010 ready=0 result=0", sk.led, sk.win_ready, sk.result); end
    pulse_ok();
    checks++; if (sk.score2 !== 8'd10) begin failures++; $display("FAIL correct_score2 got=%0d exp=10", sk.score2); end
    n = 0;
    for (int i = 0; i < HOLD; i++) begin
      if (sk.result === 2'd1 && sk.led === 3'b010 && sk.win_ready === 1'b0) n++;
      tick();
    end
    checks++; if (n !== HOLD) begin failures++; $display("FAIL correct_hold_cycles got=%0d exp=%0d", n, HOLD); end
    checks++; if (sk.win_ready !== 1'b1 || sk.result !== 2'd0 || sk.led !== 3'b000) begin failures++; $display("FAIL correct_idle ready=%b result=%0d led=%b exp 1/0/000", sk.win_ready, sk.result, sk.led); end
  endtask

  task automatic test_ignore_id0();
    sk.win_valid = 1'b1; sk.win_id = 2'd0;
    repeat (3) tick();
    checks++; if (sk.win_ready !== 1'b1 || sk.led !== 3'b000) begin failures++; $display("FAIL id0_ignored ready=%b led=%b exp 1/000", sk.win_ready, sk.led); end
    sk.win_valid = 1'b0;
  endtask

  task automatic test_wrong_sat();
    accept(2'd1); pulse_ok(); hold_out();
    accept(2'd1); pulse_bad();
    checks++; if (sk.score1 !== 8'd5 || sk.result !== 2'd2) begin failures++; $display("FAIL wrong_5 score1=%0d result=%0d exp 5/2", sk.score1, sk.result); end
    hold_out();
    accept(2'd1); pulse_bad();
    checks++; if (sk.score1 !== 8'd0) begin failures++; $display("FAIL wrong_0 score1=%0d exp=0", sk.score1); end
    hold_out();
    accept(2'd1); pulse_bad();
    checks++; if (sk.score1 !== 8'd0 || sk.result !== 2'd2) begin failures++; $display("FAIL wrong_sat score1=%0d result=%0d exp 0/2", sk.score1, sk.result); end
    checks++; if (sk.score2 !== 8'd10 || sk.score3 !== 8'd0) begin failures++; $display("FAIL wrong_others score2=%0d score3=%0d exp 10/0", sk.score2, sk.score3); end
    hold_out();
  endtask

  task automatic test_high_sat();
    repeat (25) begin accept(2'd1); pulse_ok(); hold_out(); end
    checks++; if (sk.score1 !== 8'd250) begin failures++; $display("FAIL high_250 score1=%0d exp=250", sk.score1); end
    accept(2'd1); pulse_ok();
    checks++; if (sk.score1 !== 8'd255) begin failures++; $display("FAIL high_sat score1=%0d exp=255", sk.score1); end
    hold_out();
    accept(2'd1); pulse_ok();
    checks++; if (sk.score1 !== 8'd255) begin failures++; $display("FAIL high_sat2 score1=%0d exp=255", sk.score1); end
    hold_out();
  endtask

  task automatic test_timeout_held();
    int n;
    sk.judge_ok = 1'b1;
    repeat (2) tick();
    accept(2'd3);
    n = 0;
    while (sk.result === 2'd0 && sk.led === 3'b001 && n < 40) begin n++; tick(); end
    checks++; if (n !== TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, TO); end
    checks++; if (sk.result !== 2'd3 || sk.score3 !== 8'd0) begin failures++; $display("FAIL timeout_result result=%0d score3=%0d exp 3/0", sk.result, sk.score3); end
    hold_out();
    sk.judge_ok = 1'b0;
    tick();
    accept(2'd3);
    tick();
    sk.judge_ok = 1'b1;
    tick();
    checks++; if (sk.score3 !== 8'd10 || sk.result !== 2'd1) begin failures++; $display("FAIL held_first score3=%0d result=%0d exp 10/1", sk.score3, sk.result); end
    hold_out();
    accept(2'd3);
    n = 0;
    while (sk.result === 2'd0 && sk.led === 3'b001 && n < 40) begin n++; tick(); end
    checks++; if (n !== TO || sk.result !== 2'd3 || sk.score3 !== 8'd10) begin failures++; $display("FAIL held_once cycles=%0d result=%0d score3=%0d exp %0d/3/10", n, sk.result, sk.score3, TO); end
    sk.judge_ok = 1'b0;
    hold_out();
  endtask

  task automatic test_both_edges();
    int n;
    accept(2'd2);
    sk.judge_ok = 1'b1; sk.judge_bad = 1'b1;
    tick();
    checks++; if (sk.result !== 2'd0 || sk.led !== 3'b010 || sk.win_ready !== 1'b0 || sk.score2 !== 8'd10) begin failures++; $display("FAIL both_stay result=%0d led=%b ready=%b score2=%0d exp 0/010/0/10", sk.result, sk.led, sk.win_ready, sk.score2); end
    sk.judge_ok = 1'b0;
    tick();
    sk.judge_ok = 1'b1;
    tick();
    checks++; if (sk.result !== 2'd1 || sk.score2 !== 8'd20) begin failures++; $display("FAIL both_then_ok result=%0d score2=%0d exp 1/20", sk.result, sk.score2); end
    sk.judge_ok = 1'b0; sk.judge_bad = 1'b0;
    hold_out();
    accept(2'd2);
    repeat (4) tick();
    sk.judge_ok = 1'b1; sk.judge_bad = 1'b1;
    tick();
    sk.judge_ok = 1'b0; sk.judge_bad = 1'b0;
    n = 0;
    while (sk.result === 2'd0 && sk.led === 3'b010 && n < 40) begin n++; tick(); end
    checks++; if (n !== TO - 5 || sk.result !== 2'd3 || sk.score2 !== 8'd20) begin failures++; $display("FAIL both_timer cycles=%0d result=%0d score2=%0d exp %0d/3/20", n, sk.result, sk.score2, TO - 5); end
    hold_out();
  endtask

  task automatic test_clear_priority();
    sk.win_valid = 1'b1; sk.win_id = 2'd1; sk.score_clear = 1'b1;
    tick();
    sk.win_valid = 1'b0; sk.win_id = 2'd0; sk.score_clear = 1'b0;
    checks++; if (sk.win_ready !== 1'b1 || sk.led !== 3'b000) begin failures++; $display("FAIL clear_vs_win ready=%b led=%b exp 1/000", sk.win_ready, sk.led); end
    checks++; if ({sk.score1, sk.score2, sk.score3} !== 24'd0) begin failures++; $display("FAIL clear_scores got=%0d/%0d/%0d exp 0/0/0", sk.score1, sk.score2, sk.score3); end
    accept(2'd3);
    sk.judge_ok = 1'b1; sk.score_clear = 1'b1;
    tick();
    sk.judge_ok = 1'b0; sk.score_clear = 1'b0;
    checks++; if (sk.result !== 2'd0 || sk.led !== 3'b000 || sk.score3 !== 8'd0 || sk.win_ready !== 1'b1) begin failures++; $display("FAIL clear_vs_verdict result=%0d led=%b score3=%0d ready=%b exp 0/000/0/1", sk.result, sk.led, sk.score3, sk.win_ready); end
  endtask

  task automatic test_clear_hold();
    accept(2'd1); pulse_ok();
    checks++; if (sk.score1 !== 8'd10) begin failures++; $display("FAIL clear_hold_pre score1=%0d exp=10", sk.score1); end
    repeat (3) tick();
    sk.score_clear = 1'b1;
    tick();
    sk.score_clear = 1'b0;
    checks++; if (sk.win_ready !== 1'b1 || sk.led !== 3'b000 || sk.result !== 2'd0 || sk.score1 !== 8'd0) begin failures++; $display("FAIL clear_hold ready=%b led=%b result=%0d score1=%0d exp 1/000/0/0", sk.win_ready, sk.led, sk.result, sk.score1); end
  endtask

  task automatic test_reset_mid_judge();
    accept(2'd2); pulse_ok(); hold_out();
    accept(2'd2);
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    checks++; if (sk.win_ready !== 1'b1 || sk.led !== 3'b000 || sk.result !== 2'd0 || sk.score2 !== 8'd0) begin failures++; $display("FAIL reset_async ready=%b led=%b result=%0d score2=%0d exp 1/000/0/0", sk.win_ready, sk.led, sk.result, sk.score2); end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    accept(2'd2); pulse_ok();
    checks++; if (sk.score2 !== 8'd10 || sk.result !== 2'd1) begin failures++; $display("FAIL reset_after score2=%0d result=%0d exp 10/1", sk.score2, sk.result); end
    hold_out();
  endtask

  initial begin
    rst = 1'b1;
    sk.win_valid = 1'b0; sk.win_id = 2'd0;
    sk.judge_ok = 1'b0; sk.judge_bad = 1'b0; sk.score_clear = 1'b0;
    test_reset();
    test_correct();
    test_ignore_id0();
    test_wrong_sat();
    test_high_sat();
    test_timeout_held();
    test_both_edges();
    test_clear_priority();
    test_clear_hold();
    test_reset_mid_judge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter JUDGE_TIMEOUT, 300_000_000, max cycles spent in JUDGE awaiting a verdict.
REQ-002 Parameter HOLD_CYCLES, 100_000_000, cycles the result display is held.
REQ-003 Parameter PTS_CORRECT, 10, points added on a correct verdict.
REQ-004 Parameter PTS_WRONG, 5, points subtracted on a wrong verdict.
REQ-005 clk  in  1  single system clock; all logic on posedge clk.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 win_valid  in  1  buzzer winner available.
REQ-008 win_id  in  2  winning team: 1, 2 or 3; 0 is invalid.
REQ-009 win_ready  out  1  block accepts a winner this cycle.
REQ-010 judge_ok  in  1  host "correct" button, synchronous level.
REQ-011 judge_bad  in  1  host "wrong" button, synchronous level.
REQ-012 score_clear  in  1  zero all scores.
REQ-013 led  out  3  team under judgement: 100 = team1, 010 = team2, 001 = team3.
REQ-014 result  out  2  0 none, 1 correct, 2 wrong, 3 timeout.
REQ-015 score1, score2, score3  out  8 each  team scores.

Function
REQ-016 The FSM SHALL have states IDLE, JUDGE and HOLD.
REQ-017 win_ready SHALL be 1 only in IDLE.
REQ-018 A winner is accepted when win_valid && win_ready && win_id != 0; the block then latches win_id and enters JUDGE next cycle.
REQ-019 In IDLE, win_valid with win_id == 0 SHALL be ignored.
REQ-020 judge_ok and judge_bad SHALL each be rising-edge detected against a registered copy; the registered copies reset to 0.
REQ-021 Level-held judge inputs SHALL produce at most one event.
REQ-022 Edges occurring outside JUDGE SHALL be discarded, not queued.
REQ-023 In JUDGE, led SHALL show the latched team and a 32-bit timer SHALL count cycles from 0.
REQ-024 JUDGE, judge_ok edge only: the latched team's score increases by PTS_CORRECT, saturating at 255; result = 1; next state HOLD.
REQ-025 JUDGE, judge_bad edge only: the latched team's score decreases by PTS_WRONG, saturating at 0; result = 2; next state HOLD.
REQ-026 JUDGE, both edges in the same cycle: no score change; the block stays in JUDGE and the timer keeps running.
REQ-027 JUDGE, timer reaches JUDGE_TIMEOUT-1 with no verdict: no score change; result = 3; next state HOLD.
REQ-028 A verdict edge in the same cycle as the timeout SHALL take priority over the timeout.
REQ-029 Score arithmetic SHALL be computed at 9 bits before saturation, with no wrap-around.
REQ-030 HOLD SHALL keep led and result for exactly HOLD_CYCLES cycles, then enter IDLE with led = 000 and result = 0.
REQ-031 In IDLE, led SHALL be 000 and result SHALL be 0.
REQ-032 score_clear SHALL act in any state: all scores become 0, timer becomes 0, state becomes IDLE, led = 000 and result = 0 on the next cycle.
REQ-033 score_clear SHALL take priority over any verdict, timeout or win acceptance in the same cycle.
REQ-034 Only the latched team's score SHALL change on a verdict.

Reset
REQ-035 While rst = 1, the block SHALL asynchronously enter IDLE.
REQ-036 Reset values: led = 000, result = 0, scores = 0, timer = 0, latched team = 0, win_ready = 1 after release.
REQ-037 Reset mid-JUDGE or mid-HOLD SHALL abort with no score update.

Verification
Use JUDGE_TIMEOUT = 20, HOLD_CYCLES = 8, PTS_CORRECT = 10, PTS_WRONG = 5.
REQ-038 Accept team 2, then judge_ok pulse -> score2 = 10, led = 010, result = 1 for 8 cycles, then IDLE with win_ready = 1.
REQ-039 Accept team 1 with score1 = 3, then judge_bad -> score1 = 0 (saturated), result = 2; with score1 = 250 and judge_ok -> score1 = 255.
REQ-040 Accept team 3 with no verdict -> in cycle 20 of JUDGE, result = 3, score3 unchanged; a judge_ok held across entry to JUDGE counts only once.
REQ-041 judge_ok and judge_bad rise in the same cycle -> no change, still JUDGE; a later judge_ok alone -> +10.
REQ-042 Assert rst mid-JUDGE, then separately score_clear mid-HOLD -> IDLE immediately, scores zeroed, led = 000; win_valid with win_id = 0 in IDLE -> ignored.
